uart_xmit_fifo: RTL and testbench
=================================

UART_XMIT_FIFO -- requirements
Module: uart_xmit_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named sys_clk and sys_rst_l.
REQ-002 The block SHALL support parameter DEPTH, default 8: FIFO entries, power of 2, minimum 2.
REQ-003 The block SHALL support parameter BUSY_TMO, default 32: sys_clk cycles allowed for xmit_doneH to fall after xmitH.
REQ-004 The block SHALL have port sys_clk, input, 1: rising-edge clock.
REQ-005 The block SHALL have port sys_rst_l, input, 1: asynchronous active-low reset.
REQ-006 The block SHALL have port wr_enH, input, 1: host write strobe.
REQ-007 The block SHALL have port wr_dataH, input, 8: host byte.
REQ-008 The block SHALL have port fullH, output, 1: count == DEPTH.
REQ-009 The block SHALL have port emptyH, output, 1: count == 0.
REQ-010 The block SHALL have port countH, output, log2(DEPTH)+1: current occupancy.
REQ-011 The block SHALL have port ovfH, output, 1: sticky overflow flag.
REQ-012 The block SHALL have port clr_ovfH, input, 1: clears ovfH.
REQ-013 The block SHALL have port tmoH, output, 1: one-cycle pulse on busy timeout.
REQ-014 The block SHALL have port xmitH, output, 1: transmitter start pulse.
REQ-015 The block SHALL have port xmit_dataH, output, 8: byte presented to the transmitter.
REQ-016 The block SHALL have port xmit_doneH, input, 1: transmitter idle/done (high when idle, low while sending).

Function
REQ-017 The FIFO SHALL be a circular buffer with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a separate occupancy counter.
REQ-018 When wr_enH=1 and fullH=0 at a rising edge, the block SHALL store wr_dataH at the write pointer and advance the write pointer.
REQ-019 When wr_enH=1 and fullH=1, the block SHALL drop the byte, leave pointers and count unchanged, and set ovfH=1 at that edge.
REQ-020 Writes SHALL be rejected whenever fullH=1, even if a pop occurs in the same cycle.
REQ-021 ovfH SHALL stay 1 until clr_ovfH=1 is sampled; if clr_ovfH and a new overflow occur in the same cycle, ovfH SHALL be 1.
REQ-022 When a write and a pop occur in the same cycle, both SHALL take effect and countH SHALL be unchanged.
REQ-023 fullH, emptyH and countH SHALL be registered and SHALL reflect the state after the last edge.
REQ-024 The feeder FSM SHALL have states IDLE, SEND, WAIT_BUSY and WAIT_DONE.
REQ-025 IDLE: xmitH=0; if emptyH=0 and xmit_doneH=1, the FSM SHALL load xmit_dataH with mem[rptr] and go to SEND.
REQ-026 SEND SHALL last exactly 1 cycle with xmitH=1, then go to WAIT_BUSY and clear the timeout counter.
REQ-027 WAIT_BUSY: if xmit_doneH=0, the FSM SHALL go to WAIT_DONE.
REQ-028 WAIT_BUSY: otherwise the timeout counter SHALL increment; at BUSY_TMO-1 the FSM SHALL pulse tmoH for 1 cycle and return to IDLE with no pop, so the same byte is retried.
REQ-029 WAIT_DONE: when xmit_doneH=1, the FSM SHALL pop (advance rptr, count-1) and go to IDLE.
REQ-030 xmitH SHALL be registered and SHALL never be high for two consecutive cycles.
REQ-031 xmit_dataH SHALL be held stable from SEND through the pop.
REQ-032 Latency: for a byte written into an empty FIFO with the transmitter idle, at write edge N the FSM SHALL enter SEND at edge N+1, and xmitH SHALL be high during cycle N+1..N+2.
REQ-033 Bytes SHALL be transmitted in write order; one byte SHALL be in flight at most; the FIFO head SHALL not be removed until it is done.

Reset
REQ-034 While sys_rst_l=0, asynchronously: pointers=0, countH=0, emptyH=1, fullH=0, ovfH=0, tmoH=0, xmitH=0, xmit_dataH=8'h00, FSM=IDLE, timeout counter=0.
REQ-035 On reset mid-transfer, the in-flight and queued bytes SHALL be discarded, with no xmitH until a new write follows reset release.
REQ-036 Memory contents SHALL not be reset and SHALL never be visible while emptyH=1.

Verification
REQ-037 Write 8'hA5 into an empty FIFO with xmit_doneH=1 -> xmitH pulses 1 cycle at N+1 with xmit_dataH=A5; after the done low->high sequence, countH=0 and emptyH=1.
REQ-038 Write 9 bytes 00..08 back-to-back with xmit_doneH held low -> fullH=1 after 8 writes; byte 08 is dropped and ovfH=1; clr_ovfH -> ovfH=0.
REQ-039 With 8 queued and a transmitter model (done low 10 cycles after xmitH, then high) -> output order is 00..07 and rptr wraps to 0.
REQ-040 Hold xmit_doneH=1 after xmitH -> tmoH pulses after BUSY_TMO cycles; the same byte is re-sent with count unchanged.
REQ-041 With count=3, write in the same cycle as a pop -> countH stays 3; FIFO order is preserved.
REQ-042 Assert sys_rst_l=0 during WAIT_DONE -> xmitH=0 and emptyH=1 immediately; no transmit after release without a new write.

Source files
------------

// File: rtl/uart_xmit_fifo_if.sv
// Host-write and transmitter-handshake signals of the UART transmit FIFO.
// The slave modport is the FIFO. The master modport is the host/transmitter side.
interface uart_xmit_fifo_if #(
    parameter int DEPTH = 8
);
    logic                     wr_enH;
    logic [7:0]               wr_dataH;
    logic                     fullH;
    logic                     emptyH;
    logic [$clog2(DEPTH):0]   countH;
    logic                     ovfH;
    logic                     clr_ovfH;
    logic                     tmoH;
    logic                     xmitH;
    logic [7:0]               xmit_dataH;
    logic                     xmit_doneH;

    modport slave (
        input  wr_enH, wr_dataH, clr_ovfH, xmit_doneH,
        output fullH, emptyH, countH, ovfH, tmoH, xmitH, xmit_dataH
    );

    modport master (
        output wr_enH, wr_dataH, clr_ovfH, xmit_doneH,
        input  fullH, emptyH, countH, ovfH, tmoH, xmitH, xmit_dataH
    );
endinterface

// File: rtl/uart_xmit_fifo.sv
// Byte FIFO that feeds a UART transmitter one byte at a time.
// The head byte is popped only after the transmitter reports done. If the transmitter never goes busy, the byte is retried.
module uart_xmit_fifo #(
    parameter int DEPTH    = 8,
    parameter int BUSY_TMO = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst_l,
    uart_xmit_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

    // state     | meaning
    // IDLE      | wait for a queued byte and an idle transmitter
    // SEND      | one-cycle xmitH start pulse
    // WAIT_BUSY | wait for xmit_doneH to drop, bounded by BUSY_TMO
    // WAIT_DONE | transmitter busy; pop the head when done returns
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_ovf;
    logic          r_tmo;
    logic          r_xmit;
    logic [7:0]    r_xmit_data;
    logic [1:0]    r_state;
    logic [TW-1:0] r_tmo_cnt;

    logic          w_wr;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    // A full FIFO rejects writes even when a pop happens in the same cycle.
    assign w_wr  = bus.wr_enH & ~r_full;
    assign w_pop = (r_state == WAIT_DONE) & bus.xmit_doneH;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= bus.wr_dataH;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
            if (bus.wr_enH && r_full) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovfH) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_state     <= IDLE;
            r_xmit      <= 1'b0;
            r_xmit_data <= 8'h00;
            r_tmo       <= 1'b0;
            r_tmo_cnt   <= '0;
        end else begin
            r_xmit <= 1'b0;
            r_tmo  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_empty && bus.xmit_doneH) begin
                        r_xmit_data <= r_mem[r_rptr];
                        r_xmit      <= 1'b1;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    r_tmo_cnt <= '0;
                    r_state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!bus.xmit_doneH) begin
                        r_state <= WAIT_DONE;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_tmo   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.xmit_doneH) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.fullH      = r_full;
    assign bus.emptyH     = r_empty;
    assign bus.countH     = r_count;
    assign bus.ovfH       = r_ovf;
    assign bus.tmoH       = r_tmo;
    assign bus.xmitH      = r_xmit;
    assign bus.xmit_dataH = r_xmit_data;
endmodule

// File: tb/tb_uart_xmit_fifo.sv
// Directed bench for uart_xmit_fifo with hand-computed expectations.
// Inputs change on the falling edge, and outputs are sampled there too.
module tb_uart_xmit_fifo;
    localparam int DEPTH    = 8;
    localparam int BUSY_TMO = 32;

    logic sys_clk;
    logic sys_rst_l;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_xmit_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_xmit_fifo #(.DEPTH(DEPTH), .BUSY_TMO(BUSY_TMO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .bus       (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst_l = 1'b0;
        #1;
        check("rst_xmit",  32'(bus.xmitH),  32'd0);
        check("rst_empty", 32'(bus.emptyH), 32'd1);
        check("rst_count", 32'(bus.countH), 32'd0);
        tick();
        tick();
        sys_rst_l = 1'b1;
        tick();
    endtask

    // Returns at the falling edge where xmitH is first seen high.
    task automatic wait_xmit(input string tag, output logic [7:0] d);
        bit ok;
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (bus.xmitH) begin
                ok = 1'b1;
                d  = bus.xmit_dataH;
                break;
            end
            tick();
        end
        check({tag, "_seen"}, 32'(ok), 32'd1);
    endtask

    // Transmitter model: busy for 10 cycles after the start pulse, then done. An optional write lands on the pop edge.
    task automatic tx_complete(input bit wr_at_pop, input logic [7:0] wd, input logic [7:0] exp_data);
        bus.xmit_doneH = 1'b0;
        repeat (10) tick();
        check("hold_data", 32'(bus.xmit_dataH), 32'(exp_data));
        bus.xmit_doneH = 1'b1;
        bus.wr_enH     = wr_at_pop;
        bus.wr_dataH   = wd;
        tick();
        bus.wr_enH     = 1'b0;
    endtask

    logic [7:0] d;
    bit         seen;
    int         lat;
    int         xcnt;

    initial begin
        sys_rst_l      = 1'b0;
        bus.wr_enH     = 1'b0;
        bus.wr_dataH   = 8'h00;
        bus.clr_ovfH   = 1'b0;
        bus.xmit_doneH = 1'b1;
        @(negedge sys_clk);
        check("rst_count0", 32'(bus.countH),     32'd0);
        check("rst_empty0", 32'(bus.emptyH),     32'd1);
        check("rst_full0",  32'(bus.fullH),      32'd0);
        check("rst_ovf0",   32'(bus.ovfH),       32'd0);
        check("rst_tmo0",   32'(bus.tmoH),       32'd0);
        check("rst_xmit0",  32'(bus.xmitH),      32'd0);
        check("rst_data0",  32'(bus.xmit_dataH), 32'h00);
        sys_rst_l = 1'b1;
        tick();

        // A single byte, idle transmitter. Start pulse in the cycle after the write edge.
        bus.wr_enH   = 1'b1;
        bus.wr_dataH = 8'hA5;
        tick();
        bus.wr_enH   = 1'b0;
        check("lat_no_early_xmit", 32'(bus.xmitH),  32'd0);
        check("lat_count1",        32'(bus.countH), 32'd1);
        tick();
        check("lat_xmit",      32'(bus.xmitH),      32'd1);
        check("lat_data",      32'(bus.xmit_dataH), 32'hA5);
        bus.xmit_doneH = 1'b0;
        tick();
        check("xmit_one_cycle", 32'(bus.xmitH), 32'd0);
        repeat (5) tick();
        check("busy_count", 32'(bus.countH), 32'd1);
        bus.xmit_doneH = 1'b1;
        tick();
        check("pop_count", 32'(bus.countH), 32'd0);
        check("pop_empty", 32'(bus.emptyH), 32'd1);
        xcnt = 0;
        repeat (5) begin
            tick();
            if (bus.xmitH) xcnt++;
        end
        check("idle_no_xmit", 32'(xcnt), 32'd0);

        // Fill with the transmitter busy. The ninth byte overflows.
        do_reset();
        bus.xmit_doneH = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.wr_enH   = 1'b1;
            bus.wr_dataH = 8'(i);
            tick();
            if (i == 6) check("full_at7", 32'(bus.fullH), 32'd0);
            if (i == 7) check("full_at8", 32'(bus.fullH), 32'd1);
            if (i == 7) check("ovf_at8",  32'(bus.ovfH),  32'd0);
        end
        bus.wr_enH = 1'b0;
        check("ovf_set",     32'(bus.ovfH),   32'd1);
        check("ovf_count",   32'(bus.countH), 32'd8);
        check("ovf_wptr",    32'(dut.r_wptr), 32'd0);
        bus.clr_ovfH = 1'b1;
        tick();
        bus.clr_ovfH = 1'b0;
        check("ovf_clr", 32'(bus.ovfH), 32'd0);
        tick();
        check("ovf_stays_clr", 32'(bus.ovfH), 32'd0);
        bus.clr_ovfH = 1'b1;
        bus.wr_enH   = 1'b1;
        bus.wr_dataH = 8'h55;
        tick();
        bus.clr_ovfH = 1'b0;
        bus.wr_enH   = 1'b0;
        check("ovf_set_wins", 32'(bus.ovfH),   32'd1);
        check("ovf_count2",   32'(bus.countH), 32'd8);
        bus.clr_ovfH = 1'b1;
        tick();
        bus.clr_ovfH = 1'b0;

        // Drain all eight in order. Both pointers end up back at 0.
        bus.xmit_doneH = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_xmit("order", d);
            check("order_data", 32'(d), 32'(k));
            tx_complete(1'b0, 8'h00, 8'(k));
        end
        check("drain_count", 32'(bus.countH), 32'd0);
        check("drain_empty", 32'(bus.emptyH), 32'd1);
        check("drain_rptr",  32'(dut.r_rptr), 32'd0);

        // The transmitter never goes busy, so the FSM times out and retries.
        bus.wr_enH   = 1'b1;
        bus.wr_dataH = 8'h3C;
        tick();
        bus.wr_enH   = 1'b0;
        tick();
        check("tmo_first_xmit", 32'(bus.xmitH),      32'd1);
        check("tmo_first_data", 32'(bus.xmit_dataH), 32'h3C);
        seen = 1'b0;
        lat  = 0;
        xcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.xmitH) xcnt++;
            if (bus.tmoH) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        check("tmo_seen",      32'(seen), 32'd1);
        // One edge leaves SEND, then BUSY_TMO cycles in WAIT_BUSY.
        check("tmo_latency",   32'(lat),  32'(BUSY_TMO + 1));
        check("tmo_no_resend", 32'(xcnt), 32'd0);
        check("tmo_count",     32'(bus.countH), 32'd1);
        tick();
        check("tmo_width",  32'(bus.tmoH),       32'd0);
        check("retry_xmit", 32'(bus.xmitH),      32'd1);
        check("retry_data", 32'(bus.xmit_dataH), 32'h3C);
        tx_complete(1'b0, 8'h00, 8'h3C);
        check("retry_empty", 32'(bus.emptyH), 32'd1);

        // A write lands on the pop edge with three bytes queued.
        bus.xmit_doneH = 1'b0;
        bus.wr_enH     = 1'b1;
        bus.wr_dataH   = 8'h11;
        tick();
        bus.wr_dataH   = 8'h22;
        tick();
        bus.wr_dataH   = 8'h33;
        tick();
        bus.wr_enH     = 1'b0;
        check("pw_count3", 32'(bus.countH), 32'd3);
        bus.xmit_doneH = 1'b1;
        tick();
        check("pw_xmit", 32'(bus.xmitH),      32'd1);
        check("pw_data", 32'(bus.xmit_dataH), 32'h11);
        tx_complete(1'b1, 8'h44, 8'h11);
        check("pw_count_same", 32'(bus.countH), 32'd3);
        wait_xmit("pw_b1", d);
        check("pw_order1", 32'(d), 32'h22);
        tx_complete(1'b0, 8'h00, 8'h22);
        wait_xmit("pw_b2", d);
        check("pw_order2", 32'(d), 32'h33);
        tx_complete(1'b0, 8'h00, 8'h33);
        wait_xmit("pw_b3", d);
        check("pw_order3", 32'(d), 32'h44);
        tx_complete(1'b0, 8'h00, 8'h44);
        check("pw_empty", 32'(bus.emptyH), 32'd1);

        // Reset in WAIT_DONE discards everything, and nothing is sent until a new write.
        bus.wr_enH   = 1'b1;
        bus.wr_dataH = 8'h77;
        tick();
        bus.wr_dataH = 8'h88;
        tick();
        bus.wr_enH     = 1'b0;
        check("mr_xmit", 32'(bus.xmitH), 32'd1);
        bus.xmit_doneH = 1'b0;
        tick();
        tick();
        tick();
        check("mr_count_before", 32'(bus.countH), 32'd2);
        sys_rst_l = 1'b0;
        #1;
        check("mr_xmit_rst",  32'(bus.xmitH),  32'd0);
        check("mr_empty_rst", 32'(bus.emptyH), 32'd1);
        check("mr_count_rst", 32'(bus.countH), 32'd0);
        tick();
        bus.xmit_doneH = 1'b1;
        tick();
        sys_rst_l = 1'b1;
        xcnt = 0;
        repeat (20) begin
            tick();
            if (bus.xmitH) xcnt++;
        end
        check("mr_no_xmit", 32'(xcnt), 32'd0);
        bus.wr_enH   = 1'b1;
        bus.wr_dataH = 8'h99;
        tick();
        bus.wr_enH   = 1'b0;
        wait_xmit("mr_new", d);
        check("mr_new_data", 32'(d), 32'h99);
        tx_complete(1'b0, 8'h00, 8'h99);
        check("mr_final_empty", 32'(bus.emptyH), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
